// File: rtl/vram_arbiter.sv
// VRAM time-share arbiter: VDP fetches take priority with fixed latency, CPU fills idle slots.
// Optional deferral counter built when VRAM_ARB_STALL_CNT_EN is defined.
module vram_arbiter #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vdp_fetch,
  input  logic [ADDR_W-1:0] vdp_addr,
  output logic [7:0]        vdp_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  output logic [15:0]       cpu_stall_cnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  // state | meaning
  // IDLE  | no CPU access outstanding, may grant
  // ISSUE | CPU access on mem_*
  // WAIT  | CPU read data returning on mem_rdata
  // DONE  | cpu_ack asserted
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e            state_q;
  logic              cpu_wr_q;
  logic              cpu_ack_q;
  logic [7:0]        cpu_rdata_q;
  logic              vdp_p1_q, vdp_p2_q;
  logic [7:0]        vdp_data_q;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              grant_cpu;

  assign grant_cpu = !vdp_fetch && (state_q == IDLE) && cpu_req;

  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    if (vdp_fetch) begin
      mem_addr_d = vdp_addr;
    end else if (grant_cpu) begin
      mem_addr_d  = cpu_addr;
      mem_we_d    = cpu_we;
      mem_wdata_d = cpu_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      vdp_p1_q    <= 1'b0;
      vdp_p2_q    <= 1'b0;
      vdp_data_q  <= '0;
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      vdp_p1_q    <= vdp_fetch;
      vdp_p2_q    <= vdp_p1_q;
      if (vdp_p2_q) vdp_data_q <= mem_rdata;
    end
  end

  // Writes commit in ISSUE and skip WAIT, giving the shorter write turnaround.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cpu_wr_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
    end else begin
      cpu_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_cpu) begin
            state_q  <= ISSUE;
            cpu_wr_q <= cpu_we;
          end
        end
        ISSUE: begin
          if (cpu_wr_q) begin
            state_q   <= DONE;
            cpu_ack_q <= 1'b1;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          cpu_rdata_q <= mem_rdata;
          cpu_ack_q   <= 1'b1;
          state_q     <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef VRAM_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt_q;
  logic        deferral;

  assign deferral = vdp_fetch && (state_q == IDLE) && cpu_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (deferral && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign cpu_stall_cnt = stall_cnt_q;
`else
  assign cpu_stall_cnt = '0;
`endif

  assign vdp_data  = vdp_data_q;
  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter with a behavioural synchronous VRAM.
module tb_vram_arbiter;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              vdp_fetch = 1'b0;
  logic [ADDR_W-1:0] vdp_addr = '0;
  logic [7:0]        vdp_data;
  logic              cpu_req = 1'b0;
  logic              cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [7:0]        cpu_wdata = '0;
  logic              cpu_ack;
  logic [7:0]        cpu_rdata;
  logic [15:0]       cpu_stall_cnt;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata = '0;

  vram_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .vdp_fetch(vdp_fetch), .vdp_addr(vdp_addr), .vdp_data(vdp_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall_cnt(cpu_stall_cnt),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { int n; logic [15:0] addr; logic [7:0] data; logic [7:0] old; } vtx_t;
  typedef struct { int g; int ack; logic we; logic [15:0] addr; logic [7:0] data; } ctx_t;
  typedef struct { logic we; logic [15:0] addr; logic [7:0] wdata; } req_t;

  vtx_t vdp_q[$];
  ctx_t cpu_q[$];
  req_t txn_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ack_seen_cyc = -10;
  int stall_exp = 0;
  int vdp_period = 0;
  int vdp_next = 0;
  logic        force_vdp = 1'b0;
  logic [15:0] force_addr = '0;
  logic [7:0]  vdp_last = '0;
  logic        ag_busy = 1'b0;
  logic        ag_granted = 1'b0;
  req_t        cur;

  logic [7:0] ram    [0:65535];
  bit         ram_wr [0:65535];
  logic [7:0] shadow [0:65535];
  bit         sh_wr  [0:65535];

  function automatic logic [7:0] init_val(input logic [15:0] a);
    if (a == 16'h0123) return 8'hA5;
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
  endfunction

  function automatic logic [7:0] sh_read(input logic [15:0] a);
    return sh_wr[a] ? shadow[a] : init_val(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Behavioural VRAM: read data valid the cycle after the address.
  always @(posedge clk) begin
    mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
    if (mem_we) begin
      ram[mem_addr]    = mem_wdata;
      ram_wr[mem_addr] = 1'b1;
    end
  end

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    logic ack_exp;
    logic cpu_slot;
    if (!reset) begin
      ack_exp  = 1'b0;
      cpu_slot = 1'b0;
      if (cpu_q.size() > 0) begin
        if (cyc == cpu_q[0].g + 1) begin
          cpu_slot = 1'b1;
          check("cpu_mem_addr", mem_addr, cpu_q[0].addr);
          check("cpu_mem_we", mem_we, cpu_q[0].we);
          if (cpu_q[0].we) check("cpu_mem_wdata", mem_wdata, cpu_q[0].data);
        end
        if (cyc == cpu_q[0].ack) begin
          ack_exp = 1'b1;
          if (!cpu_q[0].we) check("cpu_rdata", cpu_rdata, cpu_q[0].data);
          void'(cpu_q.pop_front());
        end
      end
      if (!cpu_slot) check("mem_we_idle", mem_we, 0);
      check("cpu_ack", cpu_ack, ack_exp);
      if (cpu_ack) ack_seen_cyc = cyc;
      if (vdp_q.size() > 0) begin
        if (cyc == vdp_q[0].n + 1) check("vdp_mem_addr", mem_addr, vdp_q[0].addr);
        if (cyc == vdp_q[0].n + 2) check("vdp_data_early", vdp_data, vdp_q[0].old);
        if (cyc == vdp_q[0].n + 3) begin
          check("vdp_data", vdp_data, vdp_q[0].data);
          void'(vdp_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    vtx_t v;
    ctx_t c;
    logic [15:0] va;
    @(posedge clk);
    #1;
    vdp_fetch = 1'b0;
    if (force_vdp || (vdp_period != 0 && cyc >= vdp_next)) begin
      if (force_vdp) va = force_addr;
      else begin
        va = 16'h2000 + 16'($urandom_range(0, 31));
        vdp_next += vdp_period;
      end
      force_vdp = 1'b0;
      vdp_fetch = 1'b1;
      vdp_addr  = va;
      v.n = cyc; v.addr = va; v.data = sh_read(va); v.old = vdp_last;
      vdp_q.push_back(v);
      vdp_last = v.data;
    end
    if (ag_busy && ag_granted && ack_seen_cyc == cyc - 1) begin
      ag_busy = 1'b0;
      cpu_req = 1'b0;
    end else if (!ag_busy && txn_q.size() > 0) begin
      cur = txn_q.pop_front();
      cpu_req   = 1'b1;
      cpu_we    = cur.we;
      cpu_addr  = cur.addr;
      cpu_wdata = cur.wdata;
      ag_busy    = 1'b1;
      ag_granted = 1'b0;
    end
    if (ag_busy && !ag_granted) begin
      if (vdp_fetch) stall_exp++;
      else begin
        ag_granted = 1'b1;
        c.g = cyc; c.we = cur.we; c.addr = cur.addr;
        if (cur.we) begin
          c.ack = cyc + 2;
          c.data = cur.wdata;
          shadow[cur.addr] = cur.wdata;
          sh_wr[cur.addr]  = 1'b1;
        end else begin
          c.ack = cyc + 3;
          c.data = sh_read(cur.addr);
        end
        cpu_q.push_back(c);
      end
    end
  endtask

  task automatic drain();
    int k = 0;
    while ((txn_q.size() > 0 || ag_busy || cpu_q.size() > 0 || vdp_q.size() > 0) && k < 100) begin
      step();
      k++;
    end
    if (k >= 100) begin
      check("drain_pending", txn_q.size() + cpu_q.size() + vdp_q.size() + int'(ag_busy), 0);
      txn_q.delete(); cpu_q.delete(); vdp_q.delete();
      ag_busy = 1'b0; cpu_req = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vdp_data"}, vdp_data, 0);
    check({tag, "_cpu_ack"}, cpu_ack, 0);
    check({tag, "_cpu_rdata"}, cpu_rdata, 0);
    check({tag, "_stall_cnt"}, cpu_stall_cnt, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  task automatic check_stall();
`ifdef VRAM_ARB_STALL_CNT_EN
    check("stall_cnt", cpu_stall_cnt, stall_exp);
`else
    check("stall_cnt", cpu_stall_cnt, 0);
`endif
  endtask

  function automatic req_t mk(input logic we, input logic [15:0] a, input logic [7:0] d);
    req_t r;
    r.we = we; r.addr = a; r.wdata = d;
    return r;
  endfunction

  initial begin
    int k;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    force_vdp = 1'b1; force_addr = 16'h0123;
    repeat (6) step();
    drain();

    txn_q.push_back(mk(1'b1, 16'h2000, 8'h3C));
    txn_q.push_back(mk(1'b0, 16'h2000, 8'h00));
    drain();

    txn_q.push_back(mk(1'b0, 16'h2000, 8'h00));
    force_vdp = 1'b1; force_addr = 16'h2001;
    step();
    drain();
    check_stall();

    vdp_period = 8;
    vdp_next = cyc + 3;
    for (int i = 0; i < 800; i++) begin
      if (txn_q.size() == 0)
        txn_q.push_back(mk($urandom_range(0, 3) == 0, 16'h2000 + 16'($urandom_range(0, 31)),
                           8'($urandom)));
      step();
    end
    vdp_period = 0;
    drain();
    check_stall();

    txn_q.push_back(mk(1'b0, 16'h2005, 8'h00));
    k = 0;
    while (!ag_granted || !ag_busy) begin
      step();
      k++;
      if (k > 20) break;
    end
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_rst");
    cpu_q.delete(); vdp_q.delete(); txn_q.delete();
    ag_busy = 1'b0; ag_granted = 1'b0; cpu_req = 1'b0;
    stall_exp = 0; vdp_last = '0;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
    repeat (6) step();
    txn_q.push_back(mk(1'b0, 16'h2005, 8'h00));
    drain();
    check_stall();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
